// File: rtl/button_event_detector.sv
// Converts a debounced button level into registered one-cycle press/release/short/long event pulses.
// Define BUTTON_EVENT_DOUBLE_PRESS_EN to add double-press detection (WAIT_GAP state, double_press_pulse).
module button_event_detector #(
    parameter bit IN_ACTIVE_LOW    = 1'b0,
    parameter int LONG_PRESS_COUNT = 12_000_000,
    parameter int DOUBLE_GAP_COUNT = 3_000_000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic in_sig,
    output logic btn_held,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press_pulse,
    output logic long_press_pulse,
    output logic double_press_pulse
);

    localparam int CNT_MAX = (LONG_PRESS_COUNT > DOUBLE_GAP_COUNT) ? LONG_PRESS_COUNT : DOUBLE_GAP_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_COUNT - 1);

`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(DOUBLE_GAP_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG_HELD,
        WAIT_GAP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG_HELD
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_q, in_d;
    logic              prev_act_q, prev_act_d;
    logic              btn_held_q, btn_held_d;
    logic              press_pulse_q, press_pulse_d;
    logic              release_pulse_q, release_pulse_d;
    logic              short_pulse_q, short_pulse_d;
    logic              long_pulse_q, long_pulse_d;
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
    logic              second_flag_q, second_flag_d;
    logic              double_pulse_q, double_pulse_d;
`endif

    logic act;
    logic press_edge;
    logic release_edge;

    assign act          = in_q ^ IN_ACTIVE_LOW;
    assign press_edge   = act & ~prev_act_q;
    assign release_edge = ~act & prev_act_q;

    always_comb begin
        in_d            = in_sig;
        prev_act_d      = act;
        state_d         = state_q;
        cnt_d           = cnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        short_pulse_d   = 1'b0;
        long_pulse_d    = 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
        second_flag_d   = second_flag_q;
        double_pulse_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (press_edge) begin
                    press_pulse_d = 1'b1;
                    state_d       = PRESSED;
                    cnt_d         = '0;
                end
            end

            // A release in the same cycle the hold reaches the long threshold still counts as short.
            PRESSED: begin
                if (release_edge) begin
                    release_pulse_d = 1'b1;
                    cnt_d           = '0;
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
                    if (second_flag_q) begin
                        double_pulse_d = 1'b1;
                        second_flag_d  = 1'b0;
                        state_d        = IDLE;
                    end else begin
                        state_d = WAIT_GAP;
                    end
`else
                    short_pulse_d = 1'b1;
                    state_d       = IDLE;
`endif
                end else if (cnt_q == LONG_LAST) begin
                    long_pulse_d = 1'b1;
                    state_d      = LONG_HELD;
                    cnt_d        = '0;
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
                    second_flag_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            LONG_HELD: begin
                if (release_edge) begin
                    release_pulse_d = 1'b1;
                    state_d         = IDLE;
                    cnt_d           = '0;
                end
            end

`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
            // A second press landing on the final gap cycle wins, otherwise its edge would be lost.
            WAIT_GAP: begin
                if (press_edge) begin
                    press_pulse_d = 1'b1;
                    second_flag_d = 1'b1;
                    state_d       = PRESSED;
                    cnt_d         = '0;
                end else if (cnt_q == GAP_LAST) begin
                    short_pulse_d = 1'b1;
                    state_d       = IDLE;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        btn_held_d = (state_d == PRESSED) || (state_d == LONG_HELD);
    end

    // in_q resets to the inactive level so an idle button never looks like a press after reset.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            in_q            <= IN_ACTIVE_LOW;
            prev_act_q      <= 1'b0;
            state_q         <= IDLE;
            cnt_q           <= '0;
            btn_held_q      <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            short_pulse_q   <= 1'b0;
            long_pulse_q    <= 1'b0;
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
            second_flag_q   <= 1'b0;
            double_pulse_q  <= 1'b0;
`endif
        end else begin
            in_q            <= in_d;
            prev_act_q      <= prev_act_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            btn_held_q      <= btn_held_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            short_pulse_q   <= short_pulse_d;
            long_pulse_q    <= long_pulse_d;
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
            second_flag_q   <= second_flag_d;
            double_pulse_q  <= double_pulse_d;
`endif
        end
    end

    assign btn_held          = btn_held_q;
    assign press_pulse       = press_pulse_q;
    assign release_pulse     = release_pulse_q;
    assign short_press_pulse = short_pulse_q;
    assign long_press_pulse  = long_pulse_q;
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
    assign double_press_pulse = double_pulse_q;
`else
    assign double_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_detector.sv
// Self-checking bench for button_event_detector: segment table with a latency scoreboard,
// hand-written reset sequences, and a random debounced pattern checked against event invariants.
module tb_button_event_detector;

    localparam int LONG_N = 8;
    localparam int GAP_N  = 6;

    // Pulse field order: {press, release, short, long, double}
    localparam logic [4:0] P_NONE  = 5'b00000;
    localparam logic [4:0] P_PRESS = 5'b10000;
    localparam logic [4:0] P_REL   = 5'b01000;
    localparam logic [4:0] P_SHORT = 5'b00100;
    localparam logic [4:0] P_LONG  = 5'b00010;
    localparam logic [4:0] P_DBL   = 5'b00001;

    // One segment: in_sig held at lvl for len cycles; held is the expected btn_held for the whole
    // segment, p0 the pulses caused by its first cycle, pk the pulses caused by cycle k (k<0: none).
    typedef struct {
        logic       lvl;
        int         len;
        logic       held;
        logic [4:0] p0;
        int         k;
        logic [4:0] pk;
    } seg_t;

    logic sys_clk = 1'b0;
    logic rst;
    logic in_sig;
    logic btn_held;
    logic press_pulse;
    logic release_pulse;
    logic short_press_pulse;
    logic long_press_pulse;
    logic double_press_pulse;
    logic [5:0] dut_out;

    int checks = 0;
    int errors = 0;
    int press_cnt = 0;
    int rel_cnt = 0;
    int press_outcomes = 0;
    int outcome_total = 0;

    seg_t       segs[$];
    logic [5:0] exp_q[$];

    assign dut_out = {btn_held, press_pulse, release_pulse, short_press_pulse,
                      long_press_pulse, double_press_pulse};

    always #5 sys_clk = ~sys_clk;

    button_event_detector #(
        .IN_ACTIVE_LOW    (1'b1),
        .LONG_PRESS_COUNT (LONG_N),
        .DOUBLE_GAP_COUNT (GAP_N)
    ) dut (
        .sys_clk            (sys_clk),
        .rst                (rst),
        .in_sig             (in_sig),
        .btn_held           (btn_held),
        .press_pulse        (press_pulse),
        .release_pulse      (release_pulse),
        .short_press_pulse  (short_press_pulse),
        .long_press_pulse   (long_press_pulse),
        .double_press_pulse (double_press_pulse)
    );

    task automatic checkOutput(input string name, input logic [5:0] actual, input logic [5:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b (held,press,rel,short,long,dbl)", name, actual, expected);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic add_seg(input logic lvl, input int len, input logic held,
                           input logic [4:0] p0, input int k, input logic [4:0] pk);
        seg_t s;
        s.lvl  = lvl;
        s.len  = len;
        s.held = held;
        s.p0   = p0;
        s.k    = k;
        s.pk   = pk;
        segs.push_back(s);
    endtask

    // Outputs lag the driven input by two edges, so the entry pushed one call earlier is due now.
    task automatic applyStimulus(input logic lvl, input logic [5:0] expected, input int idx);
        logic [5:0] due;
        in_sig = lvl;
        exp_q.push_back(expected);
        @(posedge sys_clk);
        #1;
        if (exp_q.size() == 2) begin
            due = exp_q.pop_front();
            checkOutput($sformatf("vec%0d", idx - 1), dut_out, due);
        end
    endtask

    task automatic monitorCycle();
        int outcomes;
        @(posedge sys_clk);
        #1;
        checkOutput("press_rel_exclusive", {5'b0, press_pulse & release_pulse}, 6'b0);
        outcomes = int'(short_press_pulse) + int'(long_press_pulse) + int'(double_press_pulse);
        if (press_pulse) begin
            press_cnt++;
            press_outcomes = 0;
        end
        if (release_pulse) rel_cnt++;
        if (outcomes != 0) begin
            press_outcomes += outcomes;
            outcome_total  += outcomes;
            checkOutput("one_outcome_per_press", {5'b0, press_outcomes > 1}, 6'b0);
        end
    endtask

    initial begin
        int         idx;
        int         run;
        int         low_runs;
        logic       lvl;
        logic [4:0] pulses;
        logic [5:0] last_exp;
        logic [4:0] rel_after_rst;

        rst    = 1'b1;
        in_sig = 1'b1;

        add_seg(1'b1, 4, 1'b0, P_NONE, -1, P_NONE);
`ifdef BUTTON_EVENT_DOUBLE_PRESS_EN
        add_seg(1'b0, 3, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 10, 1'b0, P_REL, 6, P_SHORT);
        add_seg(1'b0, 20, 1'b1, P_PRESS, 8, P_LONG);
        add_seg(1'b1, 5, 1'b0, P_REL, -1, P_NONE);
        add_seg(1'b0, 8, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 10, 1'b0, P_REL, 6, P_SHORT);
        add_seg(1'b0, 9, 1'b1, P_PRESS, 8, P_LONG);
        add_seg(1'b1, 5, 1'b0, P_REL, -1, P_NONE);
        add_seg(1'b0, 3, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 4, 1'b0, P_REL, -1, P_NONE);
        add_seg(1'b0, 3, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 8, 1'b0, P_REL | P_DBL, -1, P_NONE);
        add_seg(1'b0, 3, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 6, 1'b0, P_REL, -1, P_NONE);
        add_seg(1'b0, 3, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 8, 1'b0, P_REL | P_DBL, -1, P_NONE);
        add_seg(1'b0, 3, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 7, 1'b0, P_REL, 6, P_SHORT);
        add_seg(1'b0, 3, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 10, 1'b0, P_REL, 6, P_SHORT);
        add_seg(1'b0, 3, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 3, 1'b0, P_REL, -1, P_NONE);
        add_seg(1'b0, 12, 1'b1, P_PRESS, 8, P_LONG);
        add_seg(1'b1, 6, 1'b0, P_REL, -1, P_NONE);
        rel_after_rst = P_REL;
`else
        add_seg(1'b0, 3, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 5, 1'b0, P_REL | P_SHORT, -1, P_NONE);
        add_seg(1'b0, 20, 1'b1, P_PRESS, 8, P_LONG);
        add_seg(1'b1, 5, 1'b0, P_REL, -1, P_NONE);
        add_seg(1'b0, 8, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 4, 1'b0, P_REL | P_SHORT, -1, P_NONE);
        add_seg(1'b0, 9, 1'b1, P_PRESS, 8, P_LONG);
        add_seg(1'b1, 4, 1'b0, P_REL, -1, P_NONE);
        add_seg(1'b0, 1, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 4, 1'b0, P_REL | P_SHORT, -1, P_NONE);
        add_seg(1'b0, 2, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 1, 1'b0, P_REL | P_SHORT, -1, P_NONE);
        add_seg(1'b0, 2, 1'b1, P_PRESS, -1, P_NONE);
        add_seg(1'b1, 6, 1'b0, P_REL | P_SHORT, -1, P_NONE);
        rel_after_rst = P_REL | P_SHORT;
`endif

        // Reset state
        repeat (2) begin
            @(posedge sys_clk);
            #1;
            checkOutput("reset_state", dut_out, 6'b0);
        end
        rst = 1'b0;
        @(posedge sys_clk);
        #1;
        checkOutput("idle_after_reset", dut_out, 6'b0);

        // Table-driven scenarios through the scoreboard
        idx = 0;
        foreach (segs[s]) begin
            for (int i = 0; i < segs[s].len; i++) begin
                pulses = (i == 0) ? segs[s].p0 : ((i == segs[s].k) ? segs[s].pk : P_NONE);
                applyStimulus(segs[s].lvl, {segs[s].held, pulses}, idx);
                idx++;
            end
        end
        @(posedge sys_clk);
        #1;
        last_exp = exp_q.pop_front();
        checkOutput("vec_last", dut_out, last_exp);

        // Button held through reset release
        in_sig = 1'b0;
        rst    = 1'b1;
        repeat (3) begin
            @(posedge sys_clk);
            #1;
            checkOutput("rst_held_low", dut_out, 6'b0);
        end
        rst = 1'b0;
        @(posedge sys_clk);
        #1;
        checkOutput("rst_release_e1", dut_out, 6'b0);
        @(posedge sys_clk);
        #1;
        checkOutput("rst_release_press", dut_out, {1'b1, P_PRESS});
        for (int e = 3; e <= 11; e++) begin
            @(posedge sys_clk);
            #1;
            checkOutput($sformatf("post_rst_hold_e%0d", e), dut_out, {1'b1, (e == 10) ? P_LONG : P_NONE});
        end

        // One-cycle reset in the middle of a long hold
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_long_async", dut_out, 6'b0);
        @(posedge sys_clk);
        #1;
        checkOutput("rst_mid_long_edge", dut_out, 6'b0);
        rst = 1'b0;
        @(posedge sys_clk);
        #1;
        checkOutput("rst2_release_e1", dut_out, 6'b0);
        @(posedge sys_clk);
        #1;
        checkOutput("rst2_release_press", dut_out, {1'b1, P_PRESS});
        in_sig = 1'b1;
        @(posedge sys_clk);
        #1;
        checkOutput("rst2_still_held", dut_out, {1'b1, P_NONE});
        @(posedge sys_clk);
        #1;
        checkOutput("rst2_release", dut_out, {1'b0, rel_after_rst});
        repeat (12) @(posedge sys_clk);
        #1;

        // Random debounced pattern
        low_runs = 0;
        run      = 0;
        lvl      = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            if (run == 0) begin
                lvl = ~lvl;
                run = $urandom_range(1, 12);
                if (lvl == 1'b0) low_runs++;
            end
            in_sig = lvl;
            run--;
            monitorCycle();
        end
        in_sig = 1'b1;
        repeat (20) monitorCycle();
        checkCount("random_press_count", press_cnt, low_runs);
        checkCount("random_release_count", rel_cnt, low_runs);
        checkCount("random_press_vs_release", rel_cnt, press_cnt);
`ifndef BUTTON_EVENT_DOUBLE_PRESS_EN
        checkCount("random_outcome_count", outcome_total, low_runs);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
